cv32e40p_tb_virt_periph: RTL and testbench
==========================================

# cv32e40p_tb_virt_periph

Memory-mapped virtual peripheral inside the core testbench subsystem. It is the responder on the data-bus slave port that software writes to in order to print characters, report pass/fail signatures and exit codes. It produces the `tests_passed`, `tests_failed`, `exit_valid` and `exit_value` status that the testbench top monitors to end simulation. It also buffers console characters in a FIFO and exposes a readable cycle counter.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: character FIFO entries; power of two, ≥2.
- `PASS_SIGNATURE`, 32'd123456789: SIGNATURE write value that sets pass.
- `FAIL_SIGNATURE`, 32'd1: SIGNATURE write value that sets fail.

Ports (clock and reset first; reset `rst_n` is asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_i`  in  1  request; the interconnect routes only this block's 256-byte window here
- `gnt_o`  out  1  grant (combinational)
- `addr_i`  in  8  byte offset within the window
- `we_i`  in  1  write enable
- `be_i`  in  4  byte enables
- `wdata_i`  in  32  write data
- `rvalid_o`  out  1  response valid
- `rdata_o`  out  32  read data
- `char_valid_o`  out  1  FIFO head valid
- `char_o`  out  8  FIFO head character
- `char_ready_i`  in  1  console sink accepts head
- `tests_passed_o`  out  1  sticky pass
- `tests_failed_o`  out  1  sticky fail
- `exit_valid_o`  out  1  sticky exit
- `exit_value_o`  out  32  exit code

## Operation
Register map by offset. `addr_i[1:0]` is ignored.

- 0x00 PRINT (W): pushes `wdata_i[7:0]` into the FIFO if `be_i[0]` is set. With `be_i[0]` clear the write is dropped but still acknowledged.
- 0x04 EXIT (W): `exit_value_o` ← `wdata_i`; `exit_valid_o` ← 1.
- 0x08 SIGNATURE (W):
  - `PASS_SIGNATURE` sets `tests_passed_o`.
  - `FAIL_SIGNATURE` sets `tests_failed_o`.
  - Any other value is ignored.
- 0x0C CYCLE (R): free-running 32-bit counter. It increments every cycle out of reset and wraps 0xFFFFFFFF→0. Writes are ignored.
- 0x10 LEVEL (R): zero-extended FIFO occupancy, 0..`FIFO_DEPTH`.

Unmapped offsets: writes are ignored; reads return 32'hDEADBEEF. Reads of write-only registers return 0.

Status flags:
- All four status outputs are sticky until reset.
- A later EXIT write overwrites `exit_value_o`.
- Pass and fail may both be set.

Grant and FIFO rules:
- `gnt_o = req_i` for every access, except a PRINT write when the FIFO is full (count == `FIFO_DEPTH`). That case stalls with `gnt_o` = 0 until space exists.
- A full FIFO does not admit a same-cycle push alongside a pop. Grant depends only on the registered count.
- FIFO push and pop in the same cycle leave the count unchanged.
- The head is presented when count > 0. A pop occurs when `char_valid_o` && `char_ready_i`.

## Timing
- Granted request in cycle N: `rvalid_o` = 1 in cycle N+1 for both reads and writes. `rdata_o` is registered and valid in that cycle.
- Back-to-back granted requests produce back-to-back `rvalid_o`. No outstanding-request limit beyond 1-cycle latency.
- `rdata_o` = 0 whenever `rvalid_o` = 0.
- Register updates take effect at the cycle N clock edge and are visible at N+1:
  - status outputs;
  - FIFO push;
  - LEVEL.
- PRINT into an empty FIFO: `char_valid_o` = 1 in N+1.
- CYCLE read granted in cycle N returns the counter value sampled in cycle N.
- Reset values:
  - `gnt_o` follows `req_i`.
  - `rvalid_o` = 0 and `rdata_o` = 0.
  - `char_valid_o` = 0 and `char_o` = 0.
  - All status outputs = 0, `exit_value_o` = 0.
  - Counter = 0, FIFO empty.
- Reset asserted mid-operation aborts any pending response: no `rvalid_o` after reset, and FIFO contents are discarded.

## Structure
- Package `cv32e40p_tb_periph_pkg` holds:
  - register offset localparams: `PRINT_OFS`, `EXIT_OFS`, `SIG_OFS`, `CYCLE_OFS`, `LEVEL_OFS`;
  - the unmapped read value 32'hDEADBEEF;
  - default signature constants.
- Sub-module `cv32e40p_tb_char_fifo`:
  - ports: parameterised depth, width 8, push/pop, full/empty, count;
  - implementation: pointers with an extra wrap bit.
- The top contains decode, response register, status flags and counter.

## Test plan
- Write 0x48 then 0x69 to 0x00 with `char_ready_i` = 1 → `char_o` = 0x48 then 0x69 on consecutive cycles; `rvalid_o` one cycle after each grant.
- `char_ready_i` = 0, 17 PRINT writes with depth 16 → 16 granted, 17th stalled with `gnt_o` = 0 and LEVEL reads 16; raise `char_ready_i` → 17th granted the cycle after the first pop.
- Write 0x075BCD15 to 0x08 → `tests_passed_o` = 1 next cycle, held. Separately, write 1 → `tests_failed_o` = 1. Write 5 → neither flag set.
- Write 0x00000003 to 0x04 → `exit_valid_o` = 1 and `exit_value_o` = 3 next cycle. Then write 0 → `exit_value_o` = 0 with valid still 1.
- Two CYCLE reads granted 10 cycles apart → difference 10. Force the counter to 0xFFFFFFFE → reads wrap to 0x00000000 two cycles later. Read offset 0x40 → 0xDEADBEEF.
- Assert `rst_n` low while the FIFO holds 5 chars and a read is in flight → no `rvalid_o`; all outputs 0 and LEVEL reads 0 after release.

Source files
------------

// File: rtl/cv32e40p_tb_periph_pkg.sv
// Shared constants and decode helper for the testbench virtual peripheral.
package cv32e40p_tb_periph_pkg;

    localparam logic [7:0] PRINT_OFS = 8'h00;
    localparam logic [7:0] EXIT_OFS  = 8'h04;
    localparam logic [7:0] SIG_OFS   = 8'h08;
    localparam logic [7:0] CYCLE_OFS = 8'h0C;
    localparam logic [7:0] LEVEL_OFS = 8'h10;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEADBEEF;

    localparam logic [31:0] DEFAULT_PASS_SIGNATURE = 32'd123456789;
    localparam logic [31:0] DEFAULT_FAIL_SIGNATURE = 32'd1;

    typedef enum logic [2:0] {
        REG_PRINT,
        REG_EXIT,
        REG_SIG,
        REG_CYCLE,
        REG_LEVEL,
        REG_NONE
    } reg_sel_e;

    // Word index (byte offset bits [7:2]) to register selector.
    function automatic reg_sel_e decode_offset(input logic [5:0] word_idx);
        reg_sel_e sel;
        case ({word_idx, 2'b00})
            PRINT_OFS: sel = REG_PRINT;
            EXIT_OFS:  sel = REG_EXIT;
            SIG_OFS:   sel = REG_SIG;
            CYCLE_OFS: sel = REG_CYCLE;
            LEVEL_OFS: sel = REG_LEVEL;
            default:   sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cv32e40p_tb_char_fifo.sv
// Console character FIFO; read/write pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter register.
module cv32e40p_tb_char_fifo
    import cv32e40p_tb_periph_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign empty     = (wr_ptr == rd_ptr);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    // Pointer advance; a reset discards whatever the storage still holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Character storage, only ever read through the valid head slot.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/cv32e40p_tb_virt_periph.sv
// Virtual peripheral answering the testbench data-bus slave port: console
// printing, pass/fail signatures, exit code and a readable cycle counter.
module cv32e40p_tb_virt_periph
    import cv32e40p_tb_periph_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [31:0] PASS_SIGNATURE = DEFAULT_PASS_SIGNATURE,
    parameter logic [31:0] FAIL_SIGNATURE = DEFAULT_FAIL_SIGNATURE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [7:0]  addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    reg_sel_e         sel;
    logic             is_print;
    logic             access;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;
    logic [31:0]      cycle_cnt;
    logic [31:0]      read_value;
    logic             unused_bits;

    assign unused_bits = ^{addr_i[1:0], be_i[3:1]};

    assign sel      = decode_offset(addr_i[7:2]);
    assign is_print = (sel == REG_PRINT);

    // A PRINT write stalls only on a registered full count, so a pop in the
    // same cycle never makes room for it.
    assign gnt_o     = req_i & ~(we_i & is_print & fifo_full);
    assign access    = req_i & gnt_o;
    assign fifo_push = access & we_i & is_print & be_i[0];

    assign char_valid_o = ~fifo_empty;
    assign char_o       = fifo_head;
    assign fifo_pop     = char_valid_o & char_ready_i;

    cv32e40p_tb_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_char_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (wdata_i[7:0]),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read data selection; write-only registers read as zero.
    always_comb begin
        read_value = '0;
        case (sel)
            REG_CYCLE: read_value = cycle_cnt;
            REG_LEVEL: read_value = 32'(fifo_count);
            REG_NONE:  read_value = UNMAPPED_RDATA;
            default:   read_value = '0;
        endcase
    end

    // One-cycle response; data is forced to zero whenever no response is due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= access;
            rdata_o  <= (access && !we_i) ? read_value : '0;
        end
    end

    // Sticky status flags and last exit code written by software.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else if (access && we_i) begin
            case (sel)
                REG_EXIT: begin
                    exit_valid_o <= 1'b1;
                    exit_value_o <= wdata_i;
                end
                REG_SIG: begin
                    if (wdata_i == PASS_SIGNATURE) tests_passed_o <= 1'b1;
                    if (wdata_i == FAIL_SIGNATURE) tests_failed_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Free-running cycle counter, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_tb_virt_periph.sv
// Self-checking bench for the virtual peripheral: a queue-based reference
// model compared every cycle, plus directed transactions with literal results.
module tb_cv32e40p_tb_virt_periph;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        gnt_o;
    logic [7:0]  addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        char_valid_o;
    logic [7:0]  char_o;
    logic        char_ready_i;
    logic        tests_passed_o;
    logic        tests_failed_o;
    logic        exit_valid_o;
    logic [31:0] exit_value_o;

    int checks = 0;
    int errors = 0;

    cv32e40p_tb_virt_periph #(
        .FIFO_DEPTH     (DEPTH),
        .PASS_SIGNATURE (32'd123456789),
        .FAIL_SIGNATURE (32'd1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .addr_i         (addr_i),
        .we_i           (we_i),
        .be_i           (be_i),
        .wdata_i        (wdata_i),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .char_valid_o   (char_valid_o),
        .char_o         (char_o),
        .char_ready_i   (char_ready_i),
        .tests_passed_o (tests_passed_o),
        .tests_failed_o (tests_failed_o),
        .exit_valid_o   (exit_valid_o),
        .exit_value_o   (exit_value_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model state.
    logic [7:0]  mQ[$];
    logic [31:0] mCycle     = 32'd0;
    logic        mRvalid    = 1'b0;
    logic [31:0] mRdata     = 32'd0;
    logic        mPassed    = 1'b0;
    logic        mFailed    = 1'b0;
    logic        mExitValid = 1'b0;
    logic [31:0] mExitValue = 32'd0;

    // Model step on each rising edge, then compare the DUT just after it.
    always @(posedge clk) begin : modelProc
        logic [7:0]  ofs;
        logic        gntNow;
        logic [31:0] rv;
        logic        doPush;
        ofs = {addr_i[7:2], 2'b00};
        if (!rst_n) begin
            mQ.delete();
            mCycle     = 32'd0;
            mRvalid    = 1'b0;
            mRdata     = 32'd0;
            mPassed    = 1'b0;
            mFailed    = 1'b0;
            mExitValid = 1'b0;
            mExitValue = 32'd0;
        end else begin
            gntNow = req_i && !(we_i && ofs == 8'h00 && mQ.size() == DEPTH);
            case (ofs)
                8'h00, 8'h04, 8'h08: rv = 32'd0;
                8'h0C:               rv = mCycle;
                8'h10:               rv = 32'(mQ.size());
                default:             rv = 32'hDEADBEEF;
            endcase
            mRvalid = gntNow;
            mRdata  = (gntNow && !we_i) ? rv : 32'd0;
            if (gntNow && we_i && ofs == 8'h04) begin
                mExitValid = 1'b1;
                mExitValue = wdata_i;
            end
            if (gntNow && we_i && ofs == 8'h08) begin
                if (wdata_i == 32'd123456789) mPassed = 1'b1;
                if (wdata_i == 32'd1)         mFailed = 1'b1;
            end
            doPush = gntNow && we_i && ofs == 8'h00 && be_i[0];
            if (mQ.size() > 0 && char_ready_i) void'(mQ.pop_front());
            if (doPush) mQ.push_back(wdata_i[7:0]);
            mCycle = mCycle + 32'd1;
        end
        #1;
        checkOutput("gnt", 32'(gnt_o),
                    32'(req_i && !(we_i && {addr_i[7:2], 2'b00} == 8'h00 && mQ.size() == DEPTH)));
        checkOutput("rvalid", 32'(rvalid_o), 32'(mRvalid));
        checkOutput("rdata", rdata_o, mRdata);
        checkOutput("char_valid", 32'(char_valid_o), 32'(mQ.size() > 0));
        checkOutput("char", 32'(char_o), (mQ.size() > 0) ? 32'(mQ[0]) : 32'd0);
        checkOutput("passed", 32'(tests_passed_o), 32'(mPassed));
        checkOutput("failed", 32'(tests_failed_o), 32'(mFailed));
        checkOutput("exit_valid", 32'(exit_valid_o), 32'(mExitValid));
        checkOutput("exit_value", exit_value_o, mExitValue);
    end

    // One bus access starting at a falling edge; returns at the falling edge
    // of the response cycle with the response sampled.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, output logic [31:0] rdata, output logic rvalid);
        logic granted;
        granted = 1'b0;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        be_i    = be;
        for (int i = 0; i < 64 && !granted; i++) begin
            #1;
            granted = gnt_o;
            @(negedge clk);
        end
        if (!granted) checkOutput("grant_timeout", 32'd0, 32'd1);
        req_i  = 1'b0;
        we_i   = 1'b0;
        rvalid = rvalid_o;
        rdata  = rdata_o;
    endtask

    logic [31:0] rd;
    logic [31:0] c0;
    logic        rv;

    initial begin
        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 8'h00;
        be_i = 4'h0; wdata_i = 32'd0; char_ready_i = 1'b1;

        // Reset state and combinational grant during reset.
        @(negedge clk);
        req_i = 1'b1; addr_i = 8'h0C;
        #1 checkOutput("reset_gnt_follows_req", 32'(gnt_o), 32'd1);
        req_i = 1'b0;
        #1 checkOutput("reset_gnt_low", 32'(gnt_o), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("reset_char_valid", 32'(char_valid_o), 32'd0);
        checkOutput("reset_exit_value", exit_value_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Two printed characters streamed straight out.
        applyStimulus(1'b1, 8'h00, 32'h48, 4'h1, rd, rv);
        checkOutput("print1_rvalid", 32'(rv), 32'd1);
        checkOutput("print1_char", 32'(char_o), 32'h48);
        applyStimulus(1'b1, 8'h00, 32'h69, 4'h1, rd, rv);
        checkOutput("print2_rvalid", 32'(rv), 32'd1);
        checkOutput("print2_char", 32'(char_o), 32'h69);
        @(negedge clk);
        applyStimulus(1'b1, 8'h00, 32'h7A, 4'h0, rd, rv);
        checkOutput("print_be0_rvalid", 32'(rv), 32'd1);
        checkOutput("print_be0_dropped", 32'(char_valid_o), 32'd0);

        // Fill the FIFO, then stall the 17th write until the first pop.
        char_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'h00, 32'h41 + 32'(i), 4'h1, rd, rv);
        applyStimulus(1'b0, 8'h10, 32'd0, 4'hF, rd, rv);
        checkOutput("level_full", rd, 32'd16);
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'h00; wdata_i = 32'h51; be_i = 4'h1;
        #1 checkOutput("stall_gnt0", 32'(gnt_o), 32'd0);
        @(negedge clk);
        #1 checkOutput("stall_gnt1", 32'(gnt_o), 32'd0);
        char_ready_i = 1'b1;
        #1 checkOutput("stall_gnt_before_pop", 32'(gnt_o), 32'd0);
        @(posedge clk);
        #1 checkOutput("stall_gnt_after_pop", 32'(gnt_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0;
        checkOutput("stall_rvalid", 32'(rvalid_o), 32'd1);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 8'h10, 32'd0, 4'hF, rd, rv);
        checkOutput("level_drained", rd, 32'd0);

        // Signatures: unknown value, pass, fail.
        applyStimulus(1'b1, 8'h08, 32'd5, 4'hF, rd, rv);
        checkOutput("sig5_passed", 32'(tests_passed_o), 32'd0);
        checkOutput("sig5_failed", 32'(tests_failed_o), 32'd0);
        applyStimulus(1'b1, 8'h08, 32'h075BCD15, 4'hF, rd, rv);
        checkOutput("sig_pass", 32'(tests_passed_o), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("sig_pass_held", 32'(tests_passed_o), 32'd1);
        applyStimulus(1'b1, 8'h08, 32'd1, 4'hF, rd, rv);
        checkOutput("sig_fail", 32'(tests_failed_o), 32'd1);

        // Exit code and its overwrite; write-only register reads zero.
        applyStimulus(1'b1, 8'h04, 32'd3, 4'hF, rd, rv);
        checkOutput("exit_valid", 32'(exit_valid_o), 32'd1);
        checkOutput("exit_value3", exit_value_o, 32'd3);
        applyStimulus(1'b1, 8'h04, 32'd0, 4'hF, rd, rv);
        checkOutput("exit_value0", exit_value_o, 32'd0);
        checkOutput("exit_valid_held", 32'(exit_valid_o), 32'd1);
        applyStimulus(1'b0, 8'h04, 32'd0, 4'hF, rd, rv);
        checkOutput("exit_read_zero", rd, 32'd0);

        // Cycle counter spacing, wrap and the unmapped read value.
        applyStimulus(1'b0, 8'h0C, 32'd0, 4'hF, c0, rv);
        repeat (9) @(negedge clk);
        applyStimulus(1'b0, 8'h0D, 32'd0, 4'hF, rd, rv);
        checkOutput("cycle_diff", rd - c0, 32'd10);
        force dut.cycle_cnt = 32'hFFFFFFFE;
        @(negedge clk);
        release dut.cycle_cnt;
        mCycle = 32'hFFFFFFFE;
        applyStimulus(1'b0, 8'h0C, 32'd0, 4'hF, rd, rv);
        checkOutput("cycle_pre_wrap", rd, 32'hFFFFFFFE);
        @(negedge clk);
        applyStimulus(1'b0, 8'h0C, 32'd0, 4'hF, rd, rv);
        checkOutput("cycle_wrapped", rd, 32'h00000000);
        applyStimulus(1'b0, 8'h40, 32'd0, 4'hF, rd, rv);
        checkOutput("unmapped_read", rd, 32'hDEADBEEF);

        // Reset with five buffered characters and a read in flight.
        char_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h00, 32'h30 + 32'(i), 4'h1, rd, rv);
        req_i = 1'b1; we_i = 1'b0; addr_i = 8'h10;
        @(posedge clk);
        #2 rst_n = 1'b0;
        req_i = 1'b0;
        #1 checkOutput("rst_abort_rvalid", 32'(rvalid_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("rst_char_valid", 32'(char_valid_o), 32'd0);
        checkOutput("rst_char", 32'(char_o), 32'd0);
        checkOutput("rst_passed", 32'(tests_passed_o), 32'd0);
        checkOutput("rst_failed", 32'(tests_failed_o), 32'd0);
        checkOutput("rst_exit_valid", 32'(exit_valid_o), 32'd0);
        checkOutput("rst_exit_value", exit_value_o, 32'd0);
        @(negedge clk);
        checkOutput("rst_no_rvalid", 32'(rvalid_o), 32'd0);
        applyStimulus(1'b0, 8'h10, 32'd0, 4'hF, rd, rv);
        checkOutput("rst_level", rd, 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #200000;
        checkOutput("watchdog", 32'd0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
